// File: rtl/parity_word_checker_pkg.sv
// ============================================================================
//  Module      : parity_word_checker_pkg
//  Description : Shared state encodings, default sizes and parity helper
//                for the parity word checker.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package parity_word_checker_pkg;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_COLLECT = 2'd1;
  localparam logic [1:0] ST_REPORT  = 2'd2;

  localparam int c_frame_len_default = 8;
  localparam int c_cnt_w_default     = 8;
  localparam int c_err_w             = 8;

  // Value the upstream 3-input stage places on the parity line.
  function automatic logic expected_parity(input logic [2:0] data);
    return ~^data;
  endfunction

endpackage

`default_nettype wire

// File: rtl/parity_word_checker_if.sv
// ============================================================================
//  Module      : parity_word_checker_if
//  Description : Word input and frame report handshakes of the checker.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface parity_word_checker_if;
  import parity_word_checker_pkg::*;

  logic               in_valid;
  logic               in_ready;
  logic [2:0]         in_data;
  logic               in_par;
  logic               out_valid;
  logic               out_ready;
  logic               out_ok;
  logic [c_err_w-1:0] out_err_words;

  modport master (
    output in_valid, in_data, in_par, out_ready,
    input  in_ready, out_valid, out_ok, out_err_words
  );

  modport slave (
    input  in_valid, in_data, in_par, out_ready,
    output in_ready, out_valid, out_ok, out_err_words
  );

endinterface

`default_nettype wire

// File: rtl/parity_word_checker_par3_check.sv
// ============================================================================
//  Module      : par3_check
//  Description : Flags a 3-bit word whose parity bit is not the XNOR of its
//                data bits.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module par3_check (
  input  wire logic [2:0] in_data,
  input  wire logic       in_par,
  output logic            bad
);

  assign bad = in_par ^ ~(in_data[2] ^ in_data[1] ^ in_data[0]);

endmodule

`default_nettype wire

// File: rtl/parity_word_checker.sv
// ============================================================================
//  Module      : parity_word_checker
//  Description : Checks word parity, groups words into frames and reports a
//                per-frame bad-word count plus a saturating running total.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module parity_word_checker
  import parity_word_checker_pkg::*;
#(
  parameter int FRAME_LEN = c_frame_len_default,
  parameter int CNT_W     = c_cnt_w_default
) (
  input  wire logic             clk,
  input  wire logic             rst_n,
  parity_word_checker_if.slave  bus,
  input  wire logic             clr_total,
  output logic [CNT_W-1:0]      err_total
);

  localparam logic [c_err_w-1:0] c_last_idx  = c_err_w'(FRAME_LEN - 1);
  localparam logic [CNT_W-1:0]   c_total_max = {CNT_W{1'b1}};

  logic [1:0]         r_state;
  logic [1:0]         w_state_nxt;
  logic [c_err_w-1:0] r_word_idx;
  logic [c_err_w-1:0] w_word_idx_nxt;
  logic [c_err_w-1:0] r_frame_errs;
  logic [c_err_w-1:0] w_frame_errs_nxt;
  logic [c_err_w-1:0] w_frame_errs_sum;
  logic               r_in_ready;
  logic               r_out_valid;
  logic               w_out_valid_nxt;
  logic               r_out_ok;
  logic               w_out_ok_nxt;
  logic [c_err_w-1:0] r_out_err_words;
  logic [c_err_w-1:0] w_out_err_words_nxt;
  logic [CNT_W-1:0]   r_err_total;
  logic [CNT_W-1:0]   w_err_total_nxt;
  logic               w_bad;
  logic               w_accept;
  logic               w_handoff;

  par3_check u_par3_check (
    .in_data (bus.in_data),
    .in_par  (bus.in_par),
    .bad     (w_bad)
  );

  // Gating with in_ready also keeps undriven data out of every register.
  assign w_accept         = bus.in_valid & r_in_ready;
  assign w_handoff        = r_out_valid & bus.out_ready;
  assign w_frame_errs_sum = r_frame_errs + {{(c_err_w-1){1'b0}}, w_bad};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state         <= ST_IDLE;
      r_word_idx      <= '0;
      r_frame_errs    <= '0;
      r_in_ready      <= 1'b0;
      r_out_valid     <= 1'b0;
      r_out_ok        <= 1'b0;
      r_out_err_words <= '0;
      r_err_total     <= '0;
    end else begin
      r_state         <= w_state_nxt;
      r_word_idx      <= w_word_idx_nxt;
      r_frame_errs    <= w_frame_errs_nxt;
      r_in_ready      <= (w_state_nxt != ST_REPORT);
      r_out_valid     <= w_out_valid_nxt;
      r_out_ok        <= w_out_ok_nxt;
      r_out_err_words <= w_out_err_words_nxt;
      r_err_total     <= w_err_total_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_state_nxt = ST_COLLECT;
        end
      end
      ST_COLLECT: begin
        if (w_accept && (r_word_idx == c_last_idx)) begin
          w_state_nxt = ST_REPORT;
        end
      end
      ST_REPORT: begin
        if (w_handoff) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_word_idx_nxt      = r_word_idx;
    w_frame_errs_nxt    = r_frame_errs;
    w_out_valid_nxt     = r_out_valid;
    w_out_ok_nxt        = r_out_ok;
    w_out_err_words_nxt = r_out_err_words;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_word_idx_nxt   = {{(c_err_w-1){1'b0}}, 1'b1};
          w_frame_errs_nxt = {{(c_err_w-1){1'b0}}, w_bad};
        end
      end
      ST_COLLECT: begin
        if (w_accept) begin
          w_word_idx_nxt   = r_word_idx + 1'b1;
          w_frame_errs_nxt = w_frame_errs_sum;
          if (r_word_idx == c_last_idx) begin
            w_out_valid_nxt     = 1'b1;
            w_out_ok_nxt        = (w_frame_errs_sum == '0);
            w_out_err_words_nxt = w_frame_errs_sum;
          end
        end
      end
      ST_REPORT: begin
        if (w_handoff) begin
          w_out_valid_nxt  = 1'b0;
          w_word_idx_nxt   = '0;
          w_frame_errs_nxt = '0;
        end
      end
      default: begin
        w_out_valid_nxt  = 1'b0;
        w_word_idx_nxt   = '0;
        w_frame_errs_nxt = '0;
      end
    endcase

    // Clear has priority over a coincident bad word.
    w_err_total_nxt = r_err_total;
    if (clr_total) begin
      w_err_total_nxt = '0;
    end else if (w_accept && w_bad && (r_err_total != c_total_max)) begin
      w_err_total_nxt = r_err_total + 1'b1;
    end
  end

  assign bus.in_ready      = r_in_ready;
  assign bus.out_valid     = r_out_valid;
  assign bus.out_ok        = r_out_ok;
  assign bus.out_err_words = r_out_err_words;
  assign err_total         = r_err_total;

endmodule

`default_nettype wire

// File: tb/tb_parity_word_checker.sv
// ============================================================================
//  Module      : tb_parity_word_checker
//  Description : Self-checking bench for parity_word_checker (CNT_W=3).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_parity_word_checker;

  localparam int FRAME_LEN = 8;
  localparam int CNT_W     = 3;
  localparam int TOTAL_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             clr_total;
  logic [CNT_W-1:0] err_total;

  parity_word_checker_if bus ();

  parity_word_checker #(
    .FRAME_LEN (FRAME_LEN),
    .CNT_W     (CNT_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .clr_total (clr_total),
    .err_total (err_total)
  );

  always #5 clk = ~clk;

  int       n_checks = 0;
  int       n_pass   = 0;
  int       n_fail   = 0;
  int       exp_total = 0;
  int       frame_bad = 0;
  int       frame_cnt = 0;
  logic     tb_clr = 1'b0;
  logic [2:0] fd [FRAME_LEN];
  logic       fp [FRAME_LEN];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic good_par(input logic [2:0] d);
    return ($countones(d) % 2) == 0;
  endfunction

  task automatic go_idle();
    bus.in_valid = 1'b0;
    bus.in_data  = 'x;
    bus.in_par   = 'x;
  endtask

  // Called at posedge+1; returns at posedge+1 after the word is accepted.
  task automatic send_word(input logic [2:0] d, input logic p);
    logic accepted;
    logic bad;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_par   = p;
    clr_total    = tb_clr;
    accepted     = 1'b0;
    for (int i = 0; i < 50 && !accepted; i++) begin
      @(negedge clk);
      if (i == 0) check("no_early_valid", 32'(bus.out_valid), 32'd0);
      if (bus.in_ready === 1'b1) begin
        @(posedge clk);
        accepted = 1'b1;
      end
    end
    #1;
    if (!accepted) begin
      check("accept_timeout", 32'd0, 32'd1);
    end else begin
      bad = (p != good_par(d));
      if (tb_clr) exp_total = 0;
      else if (bad && exp_total < TOTAL_MAX) exp_total++;
      frame_bad += int'(bad);
      frame_cnt++;
      check("err_total_word", 32'(err_total), 32'(exp_total));
    end
    clr_total = 1'b0;
    tb_clr    = 1'b0;
  endtask

  task automatic send_frame();
    for (int i = 0; i < FRAME_LEN; i++) send_word(fd[i], fp[i]);
    go_idle();
  endtask

  task automatic check_report();
    @(negedge clk);
    check("out_valid", 32'(bus.out_valid), 32'd1);
    check("out_ok", 32'(bus.out_ok), 32'(frame_bad == 0));
    check("out_err_words", 32'(bus.out_err_words), 32'(frame_bad));
    check("err_total_frame", 32'(err_total), 32'(exp_total));
  endtask

  // Called after check_report (at a negedge); returns at posedge+1.
  task automatic handoff(input int delay);
    @(posedge clk); #1;
    for (int i = 0; i < delay; i++) begin
      @(posedge clk); #1;
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    @(negedge clk);
    check("valid_drop", 32'(bus.out_valid), 32'd0);
    @(posedge clk); #1;
    frame_bad = 0;
    frame_cnt = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic       held_ok;
    logic [7:0] held_errs;

    rst_n         = 1'b0;
    clr_total     = 1'b0;
    bus.out_ready = 1'b0;
    go_idle();

    // Reset
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", 32'(bus.in_ready), 32'd0);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_ok", 32'(bus.out_ok), 32'd0);
    check("rst_err_words", 32'(bus.out_err_words), 32'd0);
    check("rst_err_total", 32'(err_total), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("rel_in_ready", 32'(bus.in_ready), 32'd1);
    check("rel_out_valid", 32'(bus.out_valid), 32'd0);

    // Clean frame
    for (int i = 0; i < FRAME_LEN; i++) begin
      fd[i] = 3'(i);
      fp[i] = good_par(3'(i));
    end
    send_frame();
    check_report();
    handoff(0);

    // Error frame: parity flipped on 3'b011 and 3'b100
    for (int i = 0; i < FRAME_LEN; i++) begin
      fd[i] = 3'(i);
      fp[i] = good_par(3'(i));
    end
    fp[3] = 1'b0;
    fp[4] = 1'b1;
    send_frame();
    check_report();
    check("two_errs_total", 32'(err_total), 32'd2);
    handoff(1);

    // Backpressure: word waiting while the report is held
    for (int i = 0; i < FRAME_LEN; i++) begin
      fd[i] = 3'(7 - i);
      fp[i] = good_par(3'(7 - i));
    end
    fp[6] = ~fp[6];
    send_frame();
    check_report();
    held_ok   = bus.out_ok;
    held_errs = bus.out_err_words;
    @(posedge clk); #1;
    bus.in_valid = 1'b1;
    bus.in_data  = 3'b001;
    bus.in_par   = good_par(3'b001);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_in_ready", 32'(bus.in_ready), 32'd0);
      check("bp_valid", 32'(bus.out_valid), 32'd1);
      check("bp_ok", 32'(bus.out_ok), 32'(held_ok));
      check("bp_errs", 32'(bus.out_err_words), 32'(held_errs));
    end
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("bp_handoff_no_accept", 32'(bus.in_ready), 32'd0);
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    frame_bad = 0;
    frame_cnt = 0;
    for (int i = 0; i < FRAME_LEN; i++) begin
      fd[i] = 3'b001 + 3'(i);
      fp[i] = good_par(fd[i]);
    end
    send_frame();
    check_report();
    handoff(0);

    // Saturation and clear
    for (int i = 0; i < FRAME_LEN; i++) begin
      fd[i] = 3'(i);
      fp[i] = ~good_par(3'(i));
    end
    send_frame();
    check_report();
    check("sat_total", 32'(err_total), 32'(TOTAL_MAX));
    handoff(0);
    send_word(3'b010, ~good_par(3'b010));
    send_word(3'b110, ~good_par(3'b110));
    check("sat_hold", 32'(err_total), 32'(TOTAL_MAX));
    tb_clr = 1'b1;
    send_word(3'b101, ~good_par(3'b101));
    check("clr_wins", 32'(err_total), 32'd0);
    send_word(3'b111, ~good_par(3'b111));
    check("after_clr", 32'(err_total), 32'd1);
    for (int i = 4; i < FRAME_LEN; i++) send_word(3'(i), good_par(3'(i)));
    go_idle();
    check_report();
    handoff(2);

    // Randomized frames with idle gaps and report stalls
    for (int f = 0; f < 6; f++) begin
      for (int i = 0; i < FRAME_LEN; i++) begin
        send_word(3'($urandom), 1'($urandom));
        if ($urandom_range(0, 3) == 0) begin
          go_idle();
          repeat ($urandom_range(1, 3)) @(posedge clk);
          #1;
        end
      end
      go_idle();
      check_report();
      handoff($urandom_range(0, 4));
    end

    // Reset in the middle of a frame
    for (int i = 0; i < 4; i++) send_word(3'(i), ~good_par(3'(i)));
    go_idle();
    rst_n = 1'b0;
    #2;
    check("mid_rst_valid", 32'(bus.out_valid), 32'd0);
    check("mid_rst_ready", 32'(bus.in_ready), 32'd0);
    check("mid_rst_total", 32'(err_total), 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    exp_total = 0;
    frame_bad = 0;
    frame_cnt = 0;
    @(posedge clk); #1;
    check("mid_rst_no_report", 32'(bus.out_valid), 32'd0);
    for (int i = 0; i < FRAME_LEN; i++) begin
      fd[i] = 3'(i);
      fp[i] = good_par(3'(i));
    end
    send_frame();
    check_report();
    check("post_rst_clean", 32'(bus.out_err_words), 32'd0);
    handoff(0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
